// File: rtl/power_detect_ctrl.sv
// rtl/power_detect_ctrl.sv - sequencing, hysteresis detect and peak tracking for the moving-sum power estimator
// All state moves on the falling edge so it lines up with the estimator it controls.
module power_detect_ctrl #(
  parameter int WIDTH        = 12,
  parameter int FLUSH_CYCLES = 2,
  parameter int FILL_CYCLES  = 33,
  parameter int ON_COUNT     = 4,
  parameter int OFF_COUNT    = 8
) (
  input  logic             ip_clock,
  input  logic             ip_reset,
  input  logic             ip_enable,
  input  logic [WIDTH-1:0] ip_power,
  input  logic [WIDTH-1:0] ip_thr_hi,
  input  logic [WIDTH-1:0] ip_thr_lo,
  input  logic             ip_peak_clr,
  output logic             op_est_reset,
  output logic [1:0]       op_state,
  output logic             op_detect,
  output logic             op_event,
  output logic             op_cfg_err,
  output logic [WIDTH-1:0] op_power_peak
);

  localparam int TMAX = (FLUSH_CYCLES > FILL_CYCLES) ? FLUSH_CYCLES : FILL_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(ON_COUNT + 1);
  localparam int BW   = $clog2(OFF_COUNT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, FILL = 2'd2, MONITOR = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic [AW-1:0]     above_cnt, above_nxt;
  logic [BW-1:0]     below_cnt, below_nxt;
  logic              detect, detect_nxt;
  logic              event_q, event_nxt;
  logic              cfg_err, cfg_nxt;
  logic [WIDTH-1:0]  peak, peak_nxt;
  logic              is_above, is_below;

  assign is_above = $signed(ip_power) > $signed(ip_thr_hi);
  assign is_below = $signed(ip_power) < $signed(ip_thr_lo);

  always_ff @(negedge ip_clock) begin
    if (!ip_reset) begin
      state     <= IDLE;
      timer     <= '0;
      above_cnt <= '0;
      below_cnt <= '0;
      detect    <= 1'b0;
      event_q   <= 1'b0;
      cfg_err   <= 1'b0;
      peak      <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      above_cnt <= above_nxt;
      below_cnt <= below_nxt;
      detect    <= detect_nxt;
      event_q   <= event_nxt;
      cfg_err   <= cfg_nxt;
      peak      <= peak_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    above_nxt  = above_cnt;
    below_nxt  = below_cnt;
    detect_nxt = detect;
    event_nxt  = 1'b0;
    cfg_nxt    = $signed(ip_thr_lo) > $signed(ip_thr_hi);
    peak_nxt   = peak;
    if (!ip_enable) begin
      state_nxt  = IDLE;
      timer_nxt  = '0;
      above_nxt  = '0;
      below_nxt  = '0;
      detect_nxt = 1'b0;
      event_nxt  = detect;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = FLUSH;
          timer_nxt = TW'(FLUSH_CYCLES - 1);
        end
        FLUSH: begin
          if (timer == '0) begin
            state_nxt = FILL;
            timer_nxt = TW'(FILL_CYCLES - 1);
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        FILL: begin
          if (timer == '0) begin
            state_nxt = MONITOR;
            above_nxt = '0;
            below_nxt = '0;
            peak_nxt  = '0;
          end else begin
            timer_nxt = timer - TW'(1);
          end
        end
        MONITOR: begin
          if ($signed(ip_power) > $signed(peak)) peak_nxt = ip_power;
          // A bad threshold pair freezes the debouncer rather than guessing a band.
          if (cfg_err) begin
            above_nxt = '0;
            below_nxt = '0;
          end else if (is_above) begin
            above_nxt = (above_cnt == AW'(ON_COUNT)) ? above_cnt : above_cnt + AW'(1);
            below_nxt = '0;
            if (!detect && above_nxt == AW'(ON_COUNT)) begin
              detect_nxt = 1'b1;
              event_nxt  = 1'b1;
            end
          end else if (is_below) begin
            below_nxt = (below_cnt == BW'(OFF_COUNT)) ? below_cnt : below_cnt + BW'(1);
            above_nxt = '0;
            if (detect && below_nxt == BW'(OFF_COUNT)) begin
              detect_nxt = 1'b0;
              event_nxt  = 1'b1;
            end
          end else begin
            above_nxt = '0;
            below_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (ip_peak_clr) peak_nxt = '0;
  end

  always_comb begin
    op_state      = state;
    op_est_reset  = (state == FILL) || (state == MONITOR);
    op_detect     = detect;
    op_event      = event_q;
    op_cfg_err    = cfg_err;
    op_power_peak = peak;
  end

endmodule

// File: tb/tb_power_detect_ctrl.sv
// tb/tb_power_detect_ctrl.sv - scoreboard bench for power_detect_ctrl
// Stimulus queues hand-computed expectations; a monitor compares after each falling edge.
module tb_power_detect_ctrl;

  logic              clk = 1'b1;
  logic              ip_reset = 1'b0;
  logic              ip_enable = 1'b0;
  logic signed [11:0] ip_power = '0;
  logic signed [11:0] ip_thr_hi = 12'sd500;
  logic signed [11:0] ip_thr_lo = 12'sd300;
  logic              ip_peak_clr = 1'b0;
  logic              op_est_reset;
  logic [1:0]        op_state;
  logic              op_detect;
  logic              op_event;
  logic              op_cfg_err;
  logic [11:0]       op_power_peak;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic        er;
    logic        det;
    logic        evt;
    logic        cfg;
    logic [11:0] peak;
  } exp_t;

  exp_t q[$];

  logic [1:0]  e_st = 2'd0;
  logic        e_er = 1'b0;
  logic        e_det = 1'b0;
  logic        e_evt = 1'b0;
  logic        e_cfg = 1'b0;
  logic [11:0] e_peak = '0;

  power_detect_ctrl dut (
    .ip_clock      (clk),
    .ip_reset      (ip_reset),
    .ip_enable     (ip_enable),
    .ip_power      (ip_power),
    .ip_thr_hi     (ip_thr_hi),
    .ip_thr_lo     (ip_thr_lo),
    .ip_peak_clr   (ip_peak_clr),
    .op_est_reset  (op_est_reset),
    .op_state      (op_state),
    .op_detect     (op_detect),
    .op_event      (op_event),
    .op_cfg_err    (op_cfg_err),
    .op_power_peak (op_power_peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [11:0] act, input logic [11:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s.%s actual=%0d expected=%0d", nm, fld, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "state", 12'(op_state), 12'(e.st));
        chk(e.name, "est_reset", 12'(op_est_reset), 12'(e.er));
        chk(e.name, "detect", 12'(op_detect), 12'(e.det));
        chk(e.name, "event", 12'(op_event), 12'(e.evt));
        chk(e.name, "cfg_err", 12'(op_cfg_err), 12'(e.cfg));
        chk(e.name, "peak", op_power_peak, e.peak);
      end
    end
  end

  task automatic step(input string nm);
    exp_t e;
    e.name = nm;
    e.st   = e_st;
    e.er   = e_er;
    e.det  = e_det;
    e.evt  = e_evt;
    e.cfg  = e_cfg;
    e.peak = e_peak;
    q.push_back(e);
    e_evt = 1'b0;
    @(posedge clk);
  endtask

  task automatic stepn(input string nm, input int n);
    for (int i = 0; i < n; i++) step(nm);
  endtask

  initial begin
    @(posedge clk);
    stepn("reset", 2);

    // Start-up: 2 FLUSH edges, 33 FILL edges; power in FILL must be ignored.
    ip_reset = 1'b1;
    ip_enable = 1'b1;
    ip_power = 12'sd600;
    e_st = 2'd1;
    stepn("flush", 2);
    e_st = 2'd2; e_er = 1'b1;
    stepn("fill", 33);
    e_st = 2'd3;
    step("mon_entry");

    e_peak = 12'd600;
    stepn("on_wait", 3);
    e_det = 1'b1; e_evt = 1'b1;
    step("on_edge");
    step("on_hold");

    ip_power = 12'sd200;
    stepn("off_wait", 7);
    e_det = 1'b0; e_evt = 1'b1;
    step("off_edge");

    ip_power = 12'sd600; stepn("rej_a", 3);
    ip_power = 12'sd400; step("rej_mid");
    ip_power = 12'sd600; stepn("rej_b", 3);
    ip_power = 12'sd200; stepn("rej_low", 7);
    ip_power = 12'sd400; step("rej_low_mid");

    ip_thr_lo = 12'sd700;
    ip_power = 12'sd800;
    e_cfg = 1'b1; e_peak = 12'd800;
    step("cfg_set");
    stepn("cfg_hold", 4);
    ip_thr_lo = 12'sd300;
    e_cfg = 1'b0;
    stepn("cfg_resume", 4);
    e_det = 1'b1; e_evt = 1'b1;
    step("cfg_detect");

    ip_power = 12'sd200; stepn("hold_low", 7);
    ip_power = 12'sd400; step("hold_mid");

    ip_peak_clr = 1'b1; ip_power = 12'sd900; e_peak = 12'd0;
    step("clr_wins");
    ip_peak_clr = 1'b0; e_peak = 12'd900;
    step("clr_next");
    ip_peak_clr = 1'b1; ip_power = 12'sd600; e_peak = 12'd0;
    step("clr_again");
    ip_peak_clr = 1'b0; ip_power = -12'sd100;
    step("neg_peak");
    ip_power = 12'sd700; e_peak = 12'd700;
    step("peak_700");

    ip_enable = 1'b0;
    e_st = 2'd0; e_er = 1'b0; e_det = 1'b0; e_evt = 1'b1;
    step("en_drop");
    step("en_idle");

    ip_enable = 1'b1;
    e_st = 2'd1;
    stepn("re_flush", 2);
    e_st = 2'd2; e_er = 1'b1;
    stepn("re_fill", 2);
    ip_reset = 1'b0;
    e_st = 2'd0; e_er = 1'b0; e_peak = 12'd0;
    stepn("rst_fill", 2);
    ip_reset = 1'b1; ip_enable = 1'b0;
    step("post_rst");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
